// File: rtl/mem_subsystem_if.sv
// Core-to-memory port bundle: one registered read port, one byte-lane write
// port, shared funct3 for access size/sign, plus the misalignment pulse.
interface mem_subsystem_if;
  logic        mem_wen;
  logic [31:0] mem_ra;
  logic [31:0] mem_wa;
  logic [31:0] mem_wd;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rd;
  logic        misaligned_err;

  modport master (
    output mem_wen, mem_ra, mem_wa, mem_wd, mem_funct3,
    input  mem_rd, misaligned_err
  );

  modport slave (
    input  mem_wen, mem_ra, mem_wa, mem_wd, mem_funct3,
    output mem_rd, misaligned_err
  );
endinterface

// File: rtl/mem_subsystem.sv
// Unified instruction/data RAM with memory-mapped LEDs and free-running
// microsecond/millisecond counters. Reads are registered (1 cycle) and
// read-first; loads are sign/zero extended from funct3.
module mem_subsystem #(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter string       INIT_FILE   = "",
  parameter int unsigned CLK_FREQ_HZ = 12000000
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_subsystem_if.slave  bus,
  output logic [31:0]     leds
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned RAM_BYTES = DEPTH_WORDS * 4;
  localparam int unsigned PRE_DIV   = CLK_FREQ_HZ / 1000000;
  localparam int unsigned PW        = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

  logic [31:0] ram_q [DEPTH_WORDS];

  logic [31:0]   rd_q, rd_d;
  logic          err_q, err_d;
  logic [31:0]   leds_q, leds_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [9:0]    sub_q, sub_d;
  logic [31:0]   micros_q, micros_d;
  logic [31:0]   millis_q, millis_d;

  logic          ra_ram, ra_led, ra_ms, ra_us;
  logic          wa_ram, wa_led;
  logic [AW-1:0] ra_idx, wa_idx;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   rext;
  logic          rd_bad, wr_bad, wr_ok;
  logic [3:0]    be;
  logic [31:0]   wdat;
  logic          ram_we, led_we, us_tick;

  assign ra_ram = bus.mem_ra < RAM_BYTES;
  assign ra_led = bus.mem_ra[31:2] == 30'h3FFF_FFFF;
  assign ra_ms  = bus.mem_ra[31:2] == 30'h3FFF_FFFE;
  assign ra_us  = bus.mem_ra[31:2] == 30'h3FFF_FFFD;
  assign wa_ram = bus.mem_wa < RAM_BYTES;
  assign wa_led = bus.mem_wa[31:2] == 30'h3FFF_FFFF;
  assign ra_idx = bus.mem_ra[AW+1:2];
  assign wa_idx = bus.mem_wa[AW+1:2];

  // Read path: address decode, lane select, extension and error check
  always_comb begin
    rword = '0;
    if (ra_ram)     rword = ram_q[ra_idx];
    else if (ra_led) rword = leds_q;
    else if (ra_ms)  rword = millis_q;
    else if (ra_us)  rword = micros_q;

    rbyte = 8'(rword >> {bus.mem_ra[1:0], 3'b000});
    rhalf = 16'(rword >> {bus.mem_ra[1], 4'b0000});

    rext   = '0;
    rd_bad = 1'b0;
    case (bus.mem_funct3)
      3'b000:  rext = {{24{rbyte[7]}}, rbyte};
      3'b100:  rext = {24'h0, rbyte};
      3'b001:  begin rext = {{16{rhalf[15]}}, rhalf}; rd_bad = bus.mem_ra[0]; end
      3'b101:  begin rext = {16'h0, rhalf};           rd_bad = bus.mem_ra[0]; end
      3'b010:  begin rext = rword;                    rd_bad = bus.mem_ra[1:0] != 2'b00; end
      default: rd_bad = 1'b1;
    endcase
    rd_d = rd_bad ? '0 : rext;
  end

  // Write path: lane enables, replicated write data and error check
  always_comb begin
    be     = '0;
    wdat   = bus.mem_wd;
    wr_bad = 1'b0;
    case (bus.mem_funct3)
      3'b000:  begin be = 4'b0001 << bus.mem_wa[1:0]; wdat = {4{bus.mem_wd[7:0]}}; end
      3'b001:  begin
                 be     = bus.mem_wa[1] ? 4'b1100 : 4'b0011;
                 wdat   = {2{bus.mem_wd[15:0]}};
                 wr_bad = bus.mem_wa[0];
               end
      3'b010:  begin be = 4'b1111; wr_bad = bus.mem_wa[1:0] != 2'b00; end
      default: wr_bad = 1'b1;
    endcase
    wr_ok  = bus.mem_wen && !wr_bad;
    ram_we = wr_ok && wa_ram;
    led_we = wr_ok && wa_led;
    err_d  = rd_bad || (bus.mem_wen && wr_bad);
  end

  // LED register and counter next-state
  always_comb begin
    leds_d = leds_q;
    if (led_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) leds_d[8*i +: 8] = wdat[8*i +: 8];
      end
    end

    us_tick  = pre_q == PW'(PRE_DIV - 1);
    pre_d    = us_tick ? '0 : pre_q + 1'b1;
    sub_d    = sub_q;
    micros_d = micros_q;
    millis_d = millis_q;
    if (us_tick) begin
      micros_d = micros_q + 1'b1;
      if (sub_q == 10'd999) begin
        sub_d    = '0;
        millis_d = millis_q + 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
  end

  // Registered read data, error pulse, LEDs and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= '0;
      err_q    <= 1'b0;
      leds_q   <= '0;
      pre_q    <= '0;
      sub_q    <= '0;
      micros_q <= '0;
      millis_q <= '0;
    end else begin
      rd_q     <= rd_d;
      err_q    <= err_d;
      leds_q   <= leds_d;
      pre_q    <= pre_d;
      sub_q    <= sub_d;
      micros_q <= micros_d;
      millis_q <= millis_d;
    end
  end

  // RAM byte-lane write; the reset branch is intentionally empty so an edge
  // seen while reset is held drops its write but never clears contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (ram_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) ram_q[wa_idx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  assign bus.mem_rd         = rd_q;
  assign bus.misaligned_err = err_q;
  assign leds               = leds_q;

endmodule
